// File: rtl/serial_rc_subtractor.sv
// ============================================================================
// Module      : serial_rc_subtractor
// Description : Digit-serial ripple-borrow subtractor, diff = a - b - bin,
//               K bits per clock, LSB digit first, valid/ready on both sides.
//               Optional macro SUB_APPROX_LSB_EN: borrow-free low APPROX_BITS.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_rc_subtractor #(
   parameter int N           = 8,
   parameter int K           = 2,
   parameter int APPROX_BITS = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] diff,
   output logic         bout
);

   localparam int c_digits = N / K;
   localparam int c_cw     = (c_digits > 1) ? $clog2(c_digits) : 1;
   localparam logic [c_cw-1:0] c_last     = c_cw'(c_digits - 1);
   localparam logic [N-1:0]    c_dig_mask = N'({K{1'b1}});

   if ((K < 1) || (K > N) || ((N % K) != 0) || (APPROX_BITS < 0) || (APPROX_BITS > N))
   begin : g_param_check
      $error("serial_rc_subtractor: illegal N/K/APPROX_BITS combination");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [c_cw-1:0] r_cnt;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic            r_br;
   logic [N-1:0]    r_diff;
   logic            r_bout;
   logic            r_in_ready;
   logic            r_out_valid;

   logic [31:0]     w_base;
   logic [K-1:0]    w_ad;
   logic [K-1:0]    w_bd;
   logic [K-1:0]    w_dd;
   logic [K-1:0]    w_approx;
   logic [K:0]      w_br;

   assign w_base = 32'(r_cnt) * 32'(K);
   assign w_ad   = K'(r_a >> w_base);
   assign w_bd   = K'(r_b >> w_base);

`ifdef SUB_APPROX_LSB_EN
   // A bit is approximate when its absolute position lies below APPROX_BITS.
   for (genvar gi = 0; gi < K; gi++) begin : g_approx
      assign w_approx[gi] = ((w_base + 32'(gi)) < 32'(APPROX_BITS));
   end
`else
   assign w_approx = '0;
`endif

   // Approximate bits emit no borrow, so the first exact bit sees borrow 0.
   always_comb begin
      w_dd    = '0;
      w_br    = '0;
      w_br[0] = r_br;
      for (int i = 0; i < K; i++) begin
         if (w_approx[i]) begin
            w_dd[i]   = w_ad[i] ^ w_bd[i];
            w_br[i+1] = 1'b0;
         end else begin
            w_dd[i]   = w_ad[i] ^ w_bd[i] ^ w_br[i];
            w_br[i+1] = (~w_ad[i] & w_bd[i]) | (~(w_ad[i] ^ w_bd[i]) & w_br[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_br        <= 1'b0;
         r_diff      <= '0;
         r_bout      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_br       <= bin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_RUN;
               end
            end
            S_RUN: begin
               r_diff <= (r_diff & ~(c_dig_mask << w_base)) | (N'(w_dd) << w_base);
               r_br   <= w_br[K];
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == c_last) begin
                  r_cnt       <= '0;
                  r_bout      <= w_br[K];
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign diff      = r_diff;
   assign bout      = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_rc_subtractor.sv
// ============================================================================
// Module      : tb_serial_rc_subtractor
// Description : Directed and random checks of serial_rc_subtractor, N=8,
//               one instance per K in {1,2,4,8} driven in lockstep.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_rc_subtractor;

   localparam int c_n  = 8;
   localparam int c_ab = 2;

`ifdef SUB_APPROX_LSB_EN
   localparam logic [7:0] c_e1 = 8'h39; localparam logic c_b1 = 1'b0;
   localparam logic [7:0] c_e2 = 8'h01; localparam logic c_b2 = 1'b0;
   localparam logic [7:0] c_e3 = 8'h07; localparam logic c_b3 = 1'b0;
   localparam logic [7:0] c_e4 = 8'h00; localparam logic c_b4 = 1'b0;
   localparam logic [7:0] c_e5 = 8'h13; localparam logic c_b5 = 1'b0;
   localparam logic [7:0] c_e6 = 8'h13; localparam logic c_b6 = 1'b0;
`else
   localparam logic [7:0] c_e1 = 8'h37; localparam logic c_b1 = 1'b0;
   localparam logic [7:0] c_e2 = 8'hFF; localparam logic c_b2 = 1'b1;
   localparam logic [7:0] c_e3 = 8'h00; localparam logic c_b3 = 1'b0;
   localparam logic [7:0] c_e4 = 8'hFF; localparam logic c_b4 = 1'b1;
   localparam logic [7:0] c_e5 = 8'h0D; localparam logic c_b5 = 1'b0;
   localparam logic [7:0] c_e6 = 8'h0C; localparam logic c_b6 = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic [3:0] in_ready_v;
   logic [3:0] out_valid_v;
   logic [3:0] bout_v;
   logic [7:0] diff_v [4];

   int n_checks;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      serial_rc_subtractor #(.N(c_n), .K(1 << g), .APPROX_BITS(c_ab)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready_v[g]),
         .a         (a),
         .b         (b),
         .bin       (bin),
         .out_valid (out_valid_v[g]),
         .out_ready (out_ready),
         .diff      (diff_v[g]),
         .bout      (bout_v[g])
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Independent golden model: 9-bit arithmetic, optional borrow-free LSBs.
   task automatic model(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                        output logic [7:0] ed, output logic eb);
      logic [8:0] r;
`ifdef SUB_APPROX_LSB_EN
      logic [8:0] hi;
      hi = {1'b0, ta >> c_ab} - {1'b0, tb >> c_ab};
      ed = ((hi[7:0] << c_ab) | ((ta ^ tb) & 8'h03));
      eb = hi[8];
      r  = '0;
`else
      r  = {1'b0, ta} - {1'b0, tb} - {8'b0, tbin};
      ed = r[7:0];
      eb = r[8];
`endif
   endtask

   task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tbin, input logic [7:0] ed, input logic eb);
      int  lat  [4];
      bit  seen [4];
      int  w;
      w = 0;
      while (!(&in_ready_v) && (w < 50)) begin
         @(posedge clk); #1;
         w++;
      end
      check_eq({tag, "_rdy"}, 32'(in_ready_v), 32'hF);
      a = ta; b = tb; bin = tbin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq({tag, "_busy"}, 32'(in_ready_v), 32'h0);
      for (int g = 0; g < 4; g++) begin
         lat[g]  = 0;
         seen[g] = 1'b0;
      end
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         for (int g = 0; g < 4; g++) begin
            if (!seen[g] && out_valid_v[g]) begin
               seen[g] = 1'b1;
               lat[g]  = c;
            end
         end
         if (seen[0] && seen[1] && seen[2] && seen[3]) break;
      end
      for (int g = 0; g < 4; g++) begin
         check_eq($sformatf("%s_lat_k%0d", tag, 1 << g), 32'(lat[g]), 32'(8 >> g));
         check_eq($sformatf("%s_diff_k%0d", tag, 1 << g), 32'(diff_v[g]), 32'(ed));
         check_eq($sformatf("%s_bout_k%0d", tag, 1 << g), 32'(bout_v[g]), 32'(eb));
      end
   endtask

   task automatic release_out(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq({tag, "_vdrop"}, 32'(out_valid_v), 32'h0);
      check_eq({tag, "_idle"}, 32'(in_ready_v), 32'hF);
   endtask

   initial begin
      logic [7:0] ed;
      logic       eb;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rbin;
      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_vld", 32'(out_valid_v), 32'h0);
      check_eq("rst_rdy", 32'(in_ready_v), 32'hF);
      check_eq("rst_diff", 32'(diff_v[1]), 32'h0);
      check_eq("rst_bout", 32'(bout_v), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op("v1", 8'h5A, 8'h23, 1'b0, c_e1, c_b1); release_out("v1");
      do_op("v2", 8'h00, 8'h01, 1'b0, c_e2, c_b2); release_out("v2");
      do_op("v3", 8'h80, 8'h7F, 1'b1, c_e3, c_b3); release_out("v3");
      do_op("v4", 8'h33, 8'h33, 1'b1, c_e4, c_b4);

      // Hold results under backpressure and try to sneak in a new operation.
      for (int c = 0; c < 10; c++) begin
         if (c == 3) begin
            a = 8'hFF; b = 8'h00; bin = 1'b0; in_valid = 1'b1;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         check_eq("bp_vld", 32'(out_valid_v), 32'hF);
         check_eq("bp_rdy", 32'(in_ready_v), 32'h0);
         check_eq("bp_diff", 32'(diff_v[1]), 32'(c_e4));
         check_eq("bp_bout", 32'(bout_v[1]), 32'(c_b4));
      end
      release_out("bp");
      @(posedge clk); #1;
      check_eq("bp_noq", 32'(out_valid_v), 32'h0);
      check_eq("bp_noq_rdy", 32'(in_ready_v), 32'hF);

      // Abort during the second RUN cycle.
      a = 8'h5A; b = 8'h23; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_eq("abort_vld", 32'(out_valid_v), 32'h0);
      check_eq("abort_diff", 32'(diff_v[1]), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("abort_rdy", 32'(in_ready_v), 32'hF);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         check_eq("abort_novld", 32'(out_valid_v), 32'h0);
      end
      do_op("post", 8'h10, 8'h03, 1'b0, c_e5, c_b5); release_out("post");
      do_op("apx", 8'h10, 8'h03, 1'b1, c_e6, c_b6); release_out("apx");

      for (int i = 0; i < 24; i++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         model(ra, rb, rbin, ed, eb);
         do_op($sformatf("rnd%0d", i), ra, rb, rbin, ed, eb);
         release_out("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
